cfg_bit_loader: RTL and testbench
=================================

# cfg_bit_loader

Serial configuration loader that drives the static select and data tie-off inputs of an array of programmable logic cells (mux-plus-flip-flop sequential cells and two-level mux combinational cells).
- Accepts a bit-serial, parity-protected configuration stream over a valid/ready handshake.
- Deserialises it into one configuration word per cell and holds the assembled configuration stable for the cell array.
- Sits between the test/programming interface and the cell array; it is the writing end of the cells' configuration inputs.

## Interface
Parameters:
- N_CELLS, 4, number of cells configured; cell index width is $clog2(N_CELLS), minimum 1.
- CFG_W, 8, configuration bits per cell. For 8, word bits 7..0 map to D00, D01, D10, D11, A1, B1, A0, B0.

Ports:
- clk  in  1  single clock, rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin loading; honoured only in IDLE, DONE, ERR.
- in_valid  in  1  stream bit valid.
- in_bit  in  1  stream data bit.
- in_ready  out  1  loader accepts in_bit this cycle.
- cfg_out  out  N_CELLS*CFG_W  assembled configuration; cell i occupies [i*CFG_W +: CFG_W].
- cfg_we  out  1  one-cycle pulse when a cell word is committed.
- cfg_addr  out  $clog2(N_CELLS)  index of the word committed with cfg_we.
- busy  out  1  high in SHIFT, PARITY, COMMIT.
- cfg_valid  out  1  full configuration loaded and parity-clean.
- err  out  1  parity failure latched.

## Operation
- A transfer occurs in a cycle where in_valid and in_ready are both high. in_bit is ignored otherwise.
- Per cell: CFG_W data bits, MSB first, then one even-parity bit. The XOR of the data bits and the parity bit must be 0.
- States and transitions:
  - IDLE: in_ready=0. start → SHIFT; clear bit_cnt and cell_cnt; drop cfg_valid.
  - SHIFT: in_ready=1. Each transfer shifts in_bit into the shift register LSB and increments bit_cnt. On the transfer with bit_cnt==CFG_W-1 → PARITY.
  - PARITY: in_ready=1. On transfer, good parity → COMMIT; bad parity → ERR.
  - COMMIT: in_ready=0 for one cycle. Write the shift register into the cfg_out slice at cell_cnt. Pulse cfg_we with cfg_addr=cell_cnt. If cell_cnt==N_CELLS-1 → DONE; else increment cell_cnt, clear bit_cnt → SHIFT.
  - DONE: cfg_valid=1, in_ready=0. start → SHIFT, same clearing as from IDLE.
  - ERR: err=1, cfg_valid=0, in_ready=0. start → SHIFT and clear err. Previously committed slices are retained, not cleared.
- start is ignored while busy.
- Slices of cfg_out change only on COMMIT and are otherwise stable.
- A new load overwrites slices one by one; cfg_valid stays 0 until the final commit.

## Timing
- Reset values: state IDLE; in_ready=0, cfg_out=0, cfg_we=0, cfg_addr=0, busy=0, cfg_valid=0, err=0; counters 0.
- Reset mid-load aborts immediately, with no partial commit.
- All outputs are registered or decoded from registered state. No combinational path from in_valid to in_ready.
- start sampled high at edge t → in_ready high in cycle t+1.
- Minimum load with in_valid held high: N_CELLS*(CFG_W+2) cycles from the first SHIFT cycle to cfg_valid high. cfg_valid rises the cycle after the last cfg_we.
- cfg_we is asserted in the COMMIT cycle. The slice write and cfg_addr are visible in that same cycle.
- Stalls (in_valid low) freeze bit_cnt and the shift register with no timeout.

## Structure
- Shared package cfg_pkg:
  - state enum (IDLE, SHIFT, PARITY, COMMIT, DONE, ERR);
  - cell field index constants (D00..B0 bit positions);
  - default CFG_W.
- One sub-module, cfg_deser: CFG_W shift register, bit counter, running parity XOR. It exposes word, last_bit and parity_ok.
- The top level holds the FSM, cell_cnt and the cfg_out register array.

## Test plan
- N_CELLS=2, CFG_W=8, continuous valid. Stream 0xA5 p0, 0x3C p0 → cfg_we at addr 0 then addr 1, cfg_out=16'h3CA5, cfg_valid high 20 cycles after the first SHIFT cycle, err=0.
- Parity error: 0x01 with p0 → ERR, err=1, cfg_valid=0, no cfg_we. Then start and stream 0x01 p1, 0xFF p0 → cfg_out=16'hFF01, err cleared.
- Backpressure: in_valid toggling every other cycle across 0x5A p0, 0x81 p0 → result identical to the continuous case, and in_ready never high in COMMIT.
- start pulsed during SHIFT and COMMIT → ignored; counters unaffected.
- Reset: clr_n low after 5 bits of cell 1 → all outputs return to reset values asynchronously. After release, state is IDLE and in_ready=0.
- Reload from DONE with 0x00 p0, 0x00 p0 → cfg_valid drops the cycle after start, slices overwrite to 0 in order, cfg_valid reasserts.

Source files
------------

// File: rtl/cfg_pkg.sv
// ---------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the serial configuration loader:
//   - loader FSM state encoding
//   - bit positions of the fields inside an 8-bit cell configuration word
//   - default configuration word width
//   - even-parity helper used by the deserialiser
// ---------------------------------------------------------------------------
package cfg_pkg;

    // Default number of configuration bits per cell
    localparam int CFG_W_DEF = 8;

    // Bit positions inside an 8-bit cell word (MSB..LSB: D00 D01 D10 D11 A1 B1 A0 B0)
    localparam int FLD_D00 = 7;
    localparam int FLD_D01 = 6;
    localparam int FLD_D10 = 5;
    localparam int FLD_D11 = 4;
    localparam int FLD_A1  = 3;
    localparam int FLD_B1  = 2;
    localparam int FLD_A0  = 1;
    localparam int FLD_B0  = 0;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_PARITY = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    // Even parity holds when the XOR of all data bits and the parity bit is 0
    function automatic logic even_parity_ok(input logic data_xor, input logic parity_bit);
        return ~(data_xor ^ parity_bit);
    endfunction

endpackage

// File: rtl/cfg_deser.sv
// ---------------------------------------------------------------------------
// cfg_deser
// MSB-first deserialiser for one cell configuration word.
//   clk, clr_n   : clock, asynchronous active-low reset
//   clear        : synchronous clear of word, bit counter and parity accumulator
//   shift_en     : accept in_bit as the next data bit
//   in_bit       : serial data bit
//   word         : assembled data bits (latest bit in the LSB)
//   last_bit     : the next accepted data bit completes the word
//   parity_ok    : in_bit, taken as the parity bit, gives even parity
// ---------------------------------------------------------------------------
module cfg_deser
    import cfg_pkg::*;
#(
    parameter int CFG_W = CFG_W_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             in_bit,
    output logic [CFG_W-1:0] word,
    output logic             last_bit,
    output logic             parity_ok
);

    localparam int CNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    logic [CFG_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;

    // Next-state for shift register, bit counter and running data XOR
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        par_d  = par_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
            par_d  = 1'b0;
        end else if (shift_en) begin
            word_d = (word_q << 1) | CFG_W'(in_bit);
            cnt_d  = cnt_q + CNT_W'(1);
            par_d  = par_q ^ in_bit;
        end else begin
            word_d = word_q;
            cnt_d  = cnt_q;
            par_d  = par_q;
        end
    end

    // Deserialiser state registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            par_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            par_q  <= par_d;
        end
    end

    assign word      = word_q;
    assign last_bit  = (cnt_q == CNT_W'(CFG_W - 1));
    assign parity_ok = even_parity_ok(par_q, in_bit);

endmodule

// File: rtl/cfg_bit_loader.sv
// ---------------------------------------------------------------------------
// cfg_bit_loader
// Bit-serial, parity-protected configuration loader for a programmable cell
// array. Each cell receives CFG_W data bits (MSB first) plus one even-parity
// bit; good words are committed into a held configuration register.
//   clk, clr_n : clock, asynchronous active-low reset
//   start      : begin a load (honoured in IDLE, DONE, ERR)
//   in_valid, in_bit, in_ready : serial stream handshake
//   cfg_out    : assembled configuration, cell i at [i*CFG_W +: CFG_W]
//   cfg_we, cfg_addr : commit pulse and committed cell index
//   busy       : loading in progress
//   cfg_valid  : complete, parity-clean configuration held
//   err        : parity failure latched
// ---------------------------------------------------------------------------
module cfg_bit_loader
    import cfg_pkg::*;
#(
    parameter int N_CELLS = 4,
    parameter int CFG_W   = CFG_W_DEF,
    localparam int IDX_W  = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic                       in_bit,
    output logic                       in_ready,
    output logic [N_CELLS*CFG_W-1:0]   cfg_out,
    output logic                       cfg_we,
    output logic [IDX_W-1:0]           cfg_addr,
    output logic                       busy,
    output logic                       cfg_valid,
    output logic                       err
);

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           cell_cnt_q, cell_cnt_d;
    logic [N_CELLS*CFG_W-1:0]   cfg_q, cfg_d;

    logic             xfer_s;
    logic             start_acc_s;
    logic             deser_clear_s;
    logic [CFG_W-1:0] word_s;
    logic             last_bit_s;
    logic             parity_ok_s;

    // in_ready depends on registered state only, never on in_valid
    assign in_ready    = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign xfer_s      = in_valid && in_ready;
    assign start_acc_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                   (state_q == ST_ERR));
    // Bit counter restarts for every new load and after every committed cell
    assign deser_clear_s = start_acc_s || (state_q == ST_COMMIT);

    cfg_deser #(
        .CFG_W (CFG_W)
    ) u_deser (
        .clk       (clk),
        .clr_n     (clr_n),
        .clear     (deser_clear_s),
        .shift_en  (xfer_s && (state_q == ST_SHIFT)),
        .in_bit    (in_bit),
        .word      (word_s),
        .last_bit  (last_bit_s),
        .parity_ok (parity_ok_s)
    );

    // FSM next state, cell counter and configuration slice update
    always_comb begin
        state_d    = state_q;
        cell_cnt_d = cell_cnt_q;
        cfg_d      = cfg_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    cell_cnt_d = '0;
                end else begin
                    state_d    = state_q;
                end
            end
            ST_SHIFT: begin
                if (xfer_s && last_bit_s) begin
                    state_d = ST_PARITY;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_PARITY: begin
                if (xfer_s && parity_ok_s) begin
                    // The slice is loaded on the edge into COMMIT so the new word
                    // is already on cfg_out while cfg_we/cfg_addr are asserted.
                    state_d = ST_COMMIT;
                    for (int i = 0; i < N_CELLS; i++) begin
                        if (cell_cnt_q == IDX_W'(i)) begin
                            cfg_d[i*CFG_W +: CFG_W] = word_s;
                        end else begin
                            cfg_d[i*CFG_W +: CFG_W] = cfg_q[i*CFG_W +: CFG_W];
                        end
                    end
                end else if (xfer_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_COMMIT: begin
                if (cell_cnt_q == IDX_W'(N_CELLS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_SHIFT;
                    cell_cnt_d = cell_cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, cell counter and configuration registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            cell_cnt_q <= '0;
            cfg_q      <= '0;
        end else begin
            state_q    <= state_d;
            cell_cnt_q <= cell_cnt_d;
            cfg_q      <= cfg_d;
        end
    end

    assign cfg_out   = cfg_q;
    assign cfg_we    = (state_q == ST_COMMIT);
    assign cfg_addr  = cell_cnt_q;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_PARITY) ||
                       (state_q == ST_COMMIT);
    assign cfg_valid = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_cfg_bit_loader.sv
// ---------------------------------------------------------------------------
// tb_cfg_bit_loader
// Directed self-checking bench for cfg_bit_loader with N_CELLS=2, CFG_W=8.
// ---------------------------------------------------------------------------
module tb_cfg_bit_loader;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic        in_valid;
    logic        in_bit;
    logic        in_ready;
    logic [15:0] cfg_out;
    logic        cfg_we;
    logic [0:0]  cfg_addr;
    logic        busy;
    logic        cfg_valid;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Commit log collected on every rising edge where cfg_we is high
    int          we_cnt     = 0;
    int          rdy_commit = 0;
    int          we_addr [0:63];
    logic [15:0] we_data [0:63];

    cfg_bit_loader #(
        .N_CELLS (2),
        .CFG_W   (8)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .cfg_out   (cfg_out),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .busy      (busy),
        .cfg_valid (cfg_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and commit monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cfg_we) begin
            we_addr[we_cnt & 63] <= int'(cfg_addr);
            we_data[we_cnt & 63] <= cfg_out;
            we_cnt <= we_cnt + 1;
            if (in_ready) rdy_commit <= rdy_commit + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Present one bit and hold it until it is accepted (bounded)
    task automatic send_bit(input logic b, input bit gap);
        int tries;
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_bit   = b;
        tries    = 0;
        while (!in_ready && tries < 20) begin
            tick();
            tries++;
        end
        if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
        tick();
    endtask

    // Send 8 data bits MSB first plus parity; optionally pulse start before bit start_at
    task automatic send_cell(input logic [7:0] d, input logic p, input bit gap, input int start_at);
        logic [8:0] frame;
        frame = {d, p};
        for (int i = 0; i < 9; i++) begin
            if (i == start_at) begin
                check_eq("busy_at_start_pulse", 32'(busy), 32'd1);
                do_start();
            end
            send_bit(frame[8-i], gap);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!cfg_valid && waited < 40) begin
            tick();
            waited++;
        end
        check_eq("cfg_valid_reached", 32'(cfg_valid), 32'd1);
    endtask

    initial begin
        int c0;
        int w;
        int base;

        clr_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        #12;
        // Reset state
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_cfg_out", 32'(cfg_out), 32'h0);
        check_eq("rst_cfg_we", 32'(cfg_we), 32'd0);
        check_eq("rst_cfg_addr", 32'(cfg_addr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(cfg_valid), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        clr_n = 1'b1;
        tick();
        tick();
        check_eq("idle_in_ready", 32'(in_ready), 32'd0);

        // Continuous load 0xA5, 0x3C
        base = we_cnt;
        do_start();
        c0 = cyc;
        check_eq("t1_ready_after_start", 32'(in_ready), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        send_cell(8'hA5, 1'b0, 1'b0, -1);
        send_cell(8'h3C, 1'b0, 1'b0, -1);
        wait_valid(w);
        check_eq("t1_latency", 32'(cyc - c0), 32'd20);
        check_eq("t1_cfg_out", 32'(cfg_out), 32'h3CA5);
        check_eq("t1_err", 32'(err), 32'd0);
        check_eq("t1_busy_done", 32'(busy), 32'd0);
        check_eq("t1_we_count", 32'(we_cnt - base), 32'd2);
        check_eq("t1_we0_addr", 32'(we_addr[base & 63]), 32'd0);
        check_eq("t1_we0_data", 32'(we_data[base & 63]), 32'h00A5);
        check_eq("t1_we1_addr", 32'(we_addr[(base + 1) & 63]), 32'd1);
        check_eq("t1_we1_data", 32'(we_data[(base + 1) & 63]), 32'h3CA5);

        // Parity error then recovery
        base = we_cnt;
        do_start();
        check_eq("t2_valid_drop", 32'(cfg_valid), 32'd0);
        send_cell(8'h01, 1'b0, 1'b0, -1);
        check_eq("t2_err", 32'(err), 32'd1);
        check_eq("t2_valid", 32'(cfg_valid), 32'd0);
        check_eq("t2_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("t2_no_we", 32'(we_cnt - base), 32'd0);
        check_eq("t2_retained", 32'(cfg_out), 32'h3CA5);
        do_start();
        check_eq("t2_err_cleared", 32'(err), 32'd0);
        send_cell(8'h01, 1'b1, 1'b0, -1);
        send_cell(8'hFF, 1'b0, 1'b0, -1);
        wait_valid(w);
        check_eq("t2_cfg_out", 32'(cfg_out), 32'hFF01);
        check_eq("t2_err_final", 32'(err), 32'd0);

        // Backpressure with in_valid toggling
        do_start();
        send_cell(8'h5A, 1'b0, 1'b1, -1);
        send_cell(8'h81, 1'b0, 1'b1, -1);
        wait_valid(w);
        check_eq("t3_cfg_out", 32'(cfg_out), 32'h815A);
        check_eq("t3_err", 32'(err), 32'd0);
        check_eq("t3_ready_in_commit", 32'(rdy_commit), 32'd0);

        // start during SHIFT and during COMMIT is ignored
        base = we_cnt;
        do_start();
        send_cell(8'hC3, 1'b0, 1'b0, 3);
        check_eq("t4_in_commit", 32'(cfg_we), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_cell(8'h66, 1'b0, 1'b0, -1);
        wait_valid(w);
        check_eq("t4_cfg_out", 32'(cfg_out), 32'h66C3);
        check_eq("t4_we_count", 32'(we_cnt - base), 32'd2);
        check_eq("t4_we1_addr", 32'(we_addr[(base + 1) & 63]), 32'd1);

        // Asynchronous reset after 5 bits of cell 1
        base = we_cnt;
        do_start();
        send_cell(8'h12, 1'b0, 1'b0, -1);
        for (int i = 7; i > 2; i--) begin
            send_bit(1'(8'h34 >> i), 1'b0);
        end
        in_valid = 1'b0;
        check_eq("t5_busy_pre", 32'(busy), 32'd1);
        check_eq("t5_partial", 32'(cfg_out), 32'h6612);
        clr_n = 1'b0;
        #2;
        check_eq("t5_rst_cfg_out", 32'(cfg_out), 32'h0);
        check_eq("t5_rst_ready", 32'(in_ready), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_valid", 32'(cfg_valid), 32'd0);
        check_eq("t5_rst_err", 32'(err), 32'd0);
        check_eq("t5_rst_we", 32'(cfg_we), 32'd0);
        check_eq("t5_rst_addr", 32'(cfg_addr), 32'd0);
        #2;
        clr_n = 1'b1;
        tick();
        tick();
        check_eq("t5_idle_ready", 32'(in_ready), 32'd0);
        check_eq("t5_idle_busy", 32'(busy), 32'd0);
        check_eq("t5_we_count", 32'(we_cnt - base), 32'd1);

        // Reload from DONE with zeros
        do_start();
        send_cell(8'hAA, 1'b0, 1'b0, -1);
        send_cell(8'h55, 1'b0, 1'b0, -1);
        wait_valid(w);
        check_eq("t6_first", 32'(cfg_out), 32'h55AA);
        do_start();
        check_eq("t6_valid_drop", 32'(cfg_valid), 32'd0);
        send_cell(8'h00, 1'b0, 1'b0, -1);
        check_eq("t6_we0", 32'(cfg_we), 32'd1);
        check_eq("t6_addr0", 32'(cfg_addr), 32'd0);
        check_eq("t6_slice0", 32'(cfg_out), 32'h5500);
        check_eq("t6_valid_mid", 32'(cfg_valid), 32'd0);
        send_cell(8'h00, 1'b0, 1'b0, -1);
        check_eq("t6_we1", 32'(cfg_we), 32'd1);
        check_eq("t6_addr1", 32'(cfg_addr), 32'd1);
        check_eq("t6_slice1", 32'(cfg_out), 32'h0000);
        check_eq("t6_valid_pre", 32'(cfg_valid), 32'd0);
        tick();
        check_eq("t6_valid_final", 32'(cfg_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
